// File: rtl/booth_ctrl_pkg.sv
// Shared types and key codes for the Booth multiplier keypad sequencer.
package booth_ctrl_pkg;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_NEG   = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ABORT = 4'hD;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/dec_digit_accum.sv
// Signed decimal operand accumulator: magnitude plus sign flag, rejects digits
// that would push the magnitude past the largest positive W-bit value.
module dec_digit_accum #(
    parameter int W = 8
) (
    input  logic                slow_clk,
    input  logic                rst,
    input  logic                digit_stb,
    input  logic [3:0]          digit,
    input  logic                neg_stb,
    input  logic                clear_stb,
    input  logic                load_first_stb,
    output logic signed [W-1:0] value,
    output logic                reject
);

    localparam int MW = W + 4;
    localparam logic [MW-1:0] MAX_POS = MW'((2 ** (W - 1)) - 1);

    logic [W-1:0]  mag_q, mag_d;
    logic          sign_q, sign_d;
    logic          rej_q, rej_d;
    logic [MW-1:0] mag_ext;
    logic [MW-1:0] cand;

    assign mag_ext = {4'b0000, mag_q};
    // mag*10 + digit, computed wide enough that the overflow compare is exact
    assign cand = (mag_ext << 3) + (mag_ext << 1) + {{(MW - 4){1'b0}}, digit};

    always_comb begin
        mag_d  = mag_q;
        sign_d = sign_q;
        rej_d  = 1'b0;
        if (clear_stb) begin
            mag_d  = '0;
            sign_d = 1'b0;
        end else if (load_first_stb) begin
            mag_d  = {{(W - 4){1'b0}}, digit};
            sign_d = 1'b0;
        end else if (digit_stb) begin
            if (cand <= MAX_POS) begin
                mag_d = cand[W-1:0];
            end else begin
                rej_d = 1'b1;
            end
        end else if (neg_stb) begin
            sign_d = ~sign_q;
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            mag_q  <= '0;
            sign_q <= 1'b0;
            rej_q  <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            sign_q <= sign_d;
            rej_q  <= rej_d;
        end
    end

    assign value  = sign_q ? -mag_q : mag_q;
    assign reject = rej_q;

endmodule

// File: rtl/booth_entry_ctrl.sv
// Keypad-driven sequencer for the Booth multiplier: operand entry, start, wait, show.
//   state   | meaning
//   ENTER_A | building operand A
//   ENTER_B | building operand B
//   START   | one-cycle mult_start pulse
//   WAIT    | waiting for mult_done, bounded by timeout
//   SHOW    | product (or timeout) on display
module booth_entry_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter int W           = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  slow_clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  mult_done,
    input  logic signed [2*W-1:0] mult_product,
    output logic signed [W-1:0]   op_a,
    output logic signed [W-1:0]   op_b,
    output logic                  mult_start,
    output logic signed [2*W-1:0] disp_value,
    output logic                  result_valid,
    output logic                  entry_err,
    output logic                  timeout_err,
    output logic [2:0]            phase
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_t                state_q, state_d;
    logic signed [W-1:0]   op_a_q, op_a_d;
    logic signed [W-1:0]   op_b_q, op_b_d;
    logic signed [2*W-1:0] prod_q, prod_d;
    logic                  good_q, good_d;
    logic                  tmo_q, tmo_d;
    logic [TW-1:0]         tmr_q, tmr_d;

    logic                  acc_digit, acc_neg, acc_clear, acc_first;
    logic signed [W-1:0]   acc_value;
    logic                  acc_reject;
    logic                  key_abort;

    dec_digit_accum #(.W(W)) u_accum (
        .slow_clk       (slow_clk),
        .rst            (rst),
        .digit_stb      (acc_digit),
        .digit          (key_code),
        .neg_stb        (acc_neg),
        .clear_stb      (acc_clear),
        .load_first_stb (acc_first),
        .value          (acc_value),
        .reject         (acc_reject)
    );

    assign key_abort = key_valid && (key_code == KEY_ABORT);

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        prod_d    = prod_q;
        good_d    = good_q;
        tmr_d     = tmr_q;
        tmo_d     = tmo_q & ~key_valid;
        acc_digit = 1'b0;
        acc_neg   = 1'b0;
        acc_clear = 1'b0;
        acc_first = 1'b0;
        // ABORT outranks everything, including a coincident mult_done
        if (key_abort) begin
            state_d   = ENTER_A;
            op_a_d    = '0;
            op_b_d    = '0;
            prod_d    = '0;
            good_d    = 1'b0;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (key_valid) begin
                        if (is_digit(key_code)) begin
                            acc_digit = 1'b1;
                        end else begin
                            case (key_code)
                                KEY_NEG:   acc_neg = 1'b1;
                                KEY_CLEAR: acc_clear = 1'b1;
                                KEY_ENTER: begin
                                    acc_clear = 1'b1;
                                    if (state_q == ENTER_A) begin
                                        op_a_d  = acc_value;
                                        state_d = ENTER_B;
                                    end else begin
                                        op_b_d  = acc_value;
                                        state_d = START;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                START: begin
                    state_d = WAIT;
                    tmr_d   = TW'(TIMEOUT_CYC - 1);
                end
                WAIT: begin
                    if (mult_done) begin
                        prod_d  = mult_product;
                        good_d  = 1'b1;
                        state_d = SHOW;
                    end else if (tmr_q == '0) begin
                        prod_d  = '0;
                        good_d  = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = SHOW;
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                SHOW: begin
                    if (key_valid && (is_digit(key_code) || key_code == KEY_ENTER ||
                                      key_code == KEY_NEG || key_code == KEY_CLEAR)) begin
                        state_d = ENTER_A;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        prod_d  = '0;
                        good_d  = 1'b0;
                        if (is_digit(key_code)) begin
                            acc_first = 1'b1;
                        end else begin
                            acc_clear = 1'b1;
                        end
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTER_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            prod_q  <= '0;
            good_q  <= 1'b0;
            tmo_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            prod_q  <= prod_d;
            good_q  <= good_d;
            tmo_q   <= tmo_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        case (state_q)
            ENTER_A, ENTER_B: disp_value = {{W{acc_value[W-1]}}, acc_value};
            START, WAIT:      disp_value = {{W{op_b_q[W-1]}}, op_b_q};
            SHOW:             disp_value = prod_q;
            default:          disp_value = '0;
        endcase
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign mult_start   = (state_q == START);
    assign result_valid = good_q;
    assign entry_err    = acc_reject;
    assign timeout_err  = tmo_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_booth_entry_ctrl.sv
// Directed bench for booth_entry_ctrl: entry, multiply handshake, overflow, timeout, reset, abort.
module tb_booth_entry_ctrl;

    logic        slow_clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        mult_done = 1'b0;
    logic [15:0] mult_product = 16'h0;
    logic [7:0]  op_a, op_b;
    logic        mult_start;
    logic [15:0] disp_value;
    logic        result_valid, entry_err, timeout_err;
    logic [2:0]  phase;

    int errors = 0;
    int checks = 0;
    int cyc;

    booth_entry_ctrl #(.W(8), .TIMEOUT_CYC(64)) dut (
        .slow_clk     (slow_clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .op_a         (op_a),
        .op_b         (op_b),
        .mult_start   (mult_start),
        .disp_value   (disp_value),
        .result_valid (result_valid),
        .entry_err    (entry_err),
        .timeout_err  (timeout_err),
        .phase        (phase)
    );

    always #5 slow_clk = ~slow_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] k);
        @(negedge slow_clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge slow_clk);
        key_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic [15:0] p);
        @(negedge slow_clk);
        mult_done    = 1'b1;
        mult_product = p;
        @(negedge slow_clk);
        mult_done    = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge slow_clk);
        rst = 1'b0;
        chk("rst_phase", phase, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_disp", disp_value, 0);
        chk("rst_start", mult_start, 0);
        chk("rst_rv", result_valid, 0);

        // 12 x 3
        key(4'd1);
        key(4'd2);
        chk("t1_disp12", disp_value, 16'd12);
        key(4'hA);
        chk("t1_phaseB", phase, 1);
        chk("t1_op_a", op_a, 8'd12);
        key(4'd3);
        key(4'hA);
        chk("t1_start_hi", mult_start, 1);
        chk("t1_op_b", op_b, 8'd3);
        @(negedge slow_clk);
        chk("t1_start_lo", mult_start, 0);
        chk("t1_wait", phase, 3);
        chk("t1_wait_disp", disp_value, 16'd3);
        chk("t1_op_a_hold", op_a, 8'd12);
        @(negedge slow_clk);
        done_pulse(16'd36);
        chk("t1_show", phase, 4);
        chk("t1_prod", disp_value, 16'd36);
        chk("t1_rv", result_valid, 1);

        // -7 x 9 entered straight from SHOW
        key(4'd7);
        chk("t2_first", phase, 0);
        chk("t2_rv_drop", result_valid, 0);
        chk("t2_disp7", disp_value, 16'd7);
        key(4'hB);
        chk("t2_neg", disp_value, 16'hFFF9);
        key(4'hA);
        chk("t2_op_a", op_a, 8'hF9);
        key(4'd9);
        key(4'hA);
        chk("t2_op_b", op_b, 8'h09);
        @(negedge slow_clk);
        done_pulse(16'hFFC1);
        chk("t2_prod", disp_value, 16'hFFC1);
        chk("t2_rv", result_valid, 1);

        // overflow rejection, then ENTER from SHOW path is not needed here
        key(4'd1);
        key(4'd2);
        key(4'd8);
        chk("t3_err", entry_err, 1);
        chk("t3_hold12", disp_value, 16'd12);
        @(negedge slow_clk);
        chk("t3_err_lo", entry_err, 0);
        key(4'd5);
        chk("t3_125", disp_value, 16'd125);
        chk("t3_err_none", entry_err, 0);
        key(4'hC);
        chk("t3_clear", disp_value, 16'd0);

        // timeout
        key(4'd2);
        key(4'hA);
        key(4'd3);
        key(4'hA);
        chk("t4_start", mult_start, 1);
        cyc = 0;
        for (int i = 0; i < 200 && phase != 3'd4; i++) begin
            @(negedge slow_clk);
            cyc++;
        end
        chk("t4_cycles", cyc, 65);
        chk("t4_phase", phase, 4);
        chk("t4_tmo", timeout_err, 1);
        chk("t4_rv", result_valid, 0);
        chk("t4_disp", disp_value, 0);
        key(4'd4);
        chk("t4_phaseA", phase, 0);
        chk("t4_disp4", disp_value, 16'd4);
        chk("t4_tmo_clr", timeout_err, 0);

        // async reset in the middle of WAIT
        key(4'hA);
        key(4'd5);
        key(4'hA);
        @(negedge slow_clk);
        chk("t5_wait", phase, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_phase", phase, 0);
        chk("t5_op_a", op_a, 0);
        chk("t5_op_b", op_b, 0);
        chk("t5_disp", disp_value, 0);
        chk("t5_start", mult_start, 0);
        @(negedge slow_clk);
        rst = 1'b0;
        done_pulse(16'd20);
        chk("t5_stray_phase", phase, 0);
        chk("t5_stray_rv", result_valid, 0);
        chk("t5_stray_disp", disp_value, 0);

        // ABORT and mult_done together in WAIT
        key(4'd3);
        key(4'hA);
        key(4'd4);
        key(4'hA);
        @(negedge slow_clk);
        chk("t6_wait", phase, 3);
        key_valid    = 1'b1;
        key_code     = 4'hD;
        mult_done    = 1'b1;
        mult_product = 16'd12;
        @(negedge slow_clk);
        key_valid = 1'b0;
        mult_done = 1'b0;
        chk("t6_phase", phase, 0);
        chk("t6_rv", result_valid, 0);
        chk("t6_op_a", op_a, 0);
        chk("t6_op_b", op_b, 0);
        chk("t6_disp", disp_value, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
